// File: rtl/dcache_port_arbiter.sv
// D-Cache port arbiter: shares one cache port between LSQ loads and
// committed-store drain, one transaction in flight, with store anti-starvation.
//
// Ports:
//   clk, rst (async, active-low), flush (kills in-flight load only)
//   ld_req_*  : load issue handshake (addr, pw, tag)
//   st_req_*  : store drain handshake (addr, be, data), st_urgent
//   dc_*      : cache request (req/we/addr/be/wdata, ready) and response
//   ld_resp_* : load result broadcast (pw, tag, data)
//   st_ack    : store completed
//   busy      : a transaction is in progress
module dcache_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned ADDR_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              ld_req_valid,
    output logic              ld_req_ready,
    input  logic [ADDR_W-1:0] ld_req_addr,
    input  logic [4:0]        ld_req_pw,
    input  logic [4:0]        ld_req_tag,
    input  logic              st_req_valid,
    output logic              st_req_ready,
    input  logic [ADDR_W-1:0] st_req_addr,
    input  logic [3:0]        st_req_be,
    input  logic [31:0]       st_req_data,
    input  logic              st_urgent,
    output logic              dc_req,
    output logic              dc_we,
    output logic [29:0]       dc_addr,
    output logic [3:0]        dc_be,
    output logic [31:0]       dc_wdata,
    input  logic              dc_ready,
    input  logic              dc_rvalid,
    input  logic [31:0]       dc_rdata,
    output logic              ld_resp_valid,
    output logic [4:0]        ld_resp_pw,
    output logic [4:0]        ld_resp_tag,
    output logic [31:0]       ld_resp_data,
    output logic              st_ack,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t            state;
    state_t            state_nxt;
    logic              kill;
    logic              kill_nxt;
    logic [3:0]        starve_cnt;
    logic              op_st;
    logic [ADDR_W-1:0] op_addr;
    logic [3:0]        op_be;
    logic [31:0]       op_data;
    logic [4:0]        op_pw;
    logic [4:0]        op_tag;

    logic              st_force;
    logic              gnt_ld;
    logic              gnt_st;
    logic              ld_flush;
    logic              rsp;

    // Grant decision; gated by rst so the ready outputs read 0 in reset.
    always_comb begin
        gnt_ld   = 1'b0;
        gnt_st   = 1'b0;
        st_force = st_req_valid && (st_urgent || starve_cnt == LIMIT);
        if (rst && state == IDLE) begin
            if (st_force) begin
                gnt_st = 1'b1;
            end else if (ld_req_valid && !flush) begin
                gnt_ld = 1'b1;
            end else if (st_req_valid) begin
                gnt_st = 1'b1;
            end
        end
    end

    assign ld_req_ready = gnt_ld;
    assign st_req_ready = gnt_st;

    // Flush only matters while the latched op is a load.
    assign ld_flush = flush && !op_st;

    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        unique case (state)
            IDLE: begin
                kill_nxt = 1'b0;
                if (gnt_ld || gnt_st) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (ld_flush && !dc_ready) begin
                    state_nxt = IDLE;
                end else if (dc_ready) begin
                    state_nxt = WAIT;
                    kill_nxt  = ld_flush;
                end
            end
            WAIT: begin
                if (dc_rvalid) begin
                    state_nxt = IDLE;
                    kill_nxt  = 1'b0;
                end else if (ld_flush) begin
                    kill_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                kill_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            kill  <= 1'b0;
        end else begin
            state <= state_nxt;
            kill  <= kill_nxt;
        end
    end

    // Counts load grants that overtook a waiting store.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= 4'd0;
        end else if (!st_req_valid || gnt_st) begin
            starve_cnt <= 4'd0;
        end else if (gnt_ld && starve_cnt != LIMIT) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Loads latch be/data as zero so the cache fields need no muxing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_st   <= 1'b0;
            op_addr <= '0;
            op_be   <= 4'd0;
            op_data <= 32'd0;
            op_pw   <= 5'd0;
            op_tag  <= 5'd0;
        end else if (gnt_ld) begin
            op_st   <= 1'b0;
            op_addr <= ld_req_addr;
            op_be   <= 4'd0;
            op_data <= 32'd0;
            op_pw   <= ld_req_pw;
            op_tag  <= ld_req_tag;
        end else if (gnt_st) begin
            op_st   <= 1'b1;
            op_addr <= st_req_addr;
            op_be   <= st_req_be;
            op_data <= st_req_data;
        end
    end

    assign dc_req   = (state == REQ);
    assign dc_we    = op_st;
    assign dc_addr  = 30'(op_addr);
    assign dc_be    = op_be;
    assign dc_wdata = op_data;

    assign rsp           = (state == WAIT) && dc_rvalid;
    assign ld_resp_valid = rsp && !op_st && !kill && !flush;
    assign ld_resp_pw    = ld_resp_valid ? op_pw : 5'd0;
    assign ld_resp_tag   = ld_resp_valid ? op_tag : 5'd0;
    assign ld_resp_data  = ld_resp_valid ? dc_rdata : 32'd0;
    assign st_ack        = rsp && op_st;
    assign busy          = (state != IDLE);

endmodule

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
Shares the single D-Cache port between the LSQ load issue path and the committed-store drain path, with at most one cache transaction outstanding. Loads normally win arbitration. Stores are protected by a starvation counter and an urgent input. The block sequences each transaction (request hold, response wait) and routes the load result back to the broadcast bus with its Pw and ROB tag. It sits between the LSQ/store buffer and the cache manage unit.

Parameters:
STARVE_LIMIT, 4, consecutive load grants allowed while a store is waiting before the store is forced through (range 1..15)
ADDR_W, 16, width of the requester address; zero-extended to the 30-bit cache word address

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-low
flush  input  1  pipeline flush; kills in-flight load only
ld_req_valid  input  1  LSQ load request valid
ld_req_ready  output  1  load accepted this cycle
ld_req_addr  input  ADDR_W  load word address
ld_req_pw  input  5  load destination physical register
ld_req_tag  input  5  load ROB tag
st_req_valid  input  1  store-drain request valid
st_req_ready  output  1  store accepted this cycle
st_req_addr  input  ADDR_W  store word address
st_req_be  input  4  store byte enables
st_req_data  input  32  store data
st_urgent  input  1  store buffer nearly full; store wins outright
dc_req  output  1  cache request valid (held until dc_ready)
dc_we  output  1  1 = write, 0 = read
dc_addr  output  30  {zeros, addr}
dc_be  output  4  byte enables (0000 for reads)
dc_wdata  output  32  write data (0 for reads)
dc_ready  input  1  cache accepts request this cycle
dc_rvalid  input  1  read data / write ack, one cycle
dc_rdata  input  32  read data
ld_resp_valid  output  1  load result broadcast, one cycle
ld_resp_pw  output  5  Pw of the completing load
ld_resp_tag  output  5  ROB tag of the completing load
ld_resp_data  output  32  load data
st_ack  output  1  store completed, one cycle
busy  output  1  state != IDLE

Behaviour:
- FSM states: IDLE, REQ, WAIT. Reset → IDLE. All outputs reset to 0. Internal registers reset to 0: starve counter, kill flag, latched op fields.
- Arbitration runs in IDLE only; ready outputs are 0 in REQ and WAIT. Grant order:
  - If st_req_valid and (st_urgent or starve_cnt == STARVE_LIMIT): grant store.
  - Else if ld_req_valid and !flush: grant load.
  - Else if st_req_valid: grant store.
- ld_req_ready / st_req_ready are combinational grant indications in IDLE. The handshake completes when valid && ready. ld_req_ready is 0 whenever flush = 1.
- On grant: latch addr, be, data, pw, tag and the op type; go to REQ. Transaction latency from grant to dc_req is one cycle (registered request).
- REQ: dc_req = 1 with fields stable until dc_ready. If dc_ready = 1, go to WAIT.
- WAIT: dc_req = 0. If dc_rvalid = 1, go to IDLE; the next grant is possible in the following cycle.
- Load completion: ld_resp_valid = WAIT && dc_rvalid && load && !kill && !flush. Data comes straight from dc_rdata in the same cycle; pw and tag come from the latched fields.
- Store completion: st_ack = WAIT && dc_rvalid && store. Stores ignore flush and kill.
- Starve counter:
  - Increments (saturating at STARVE_LIMIT) on each load grant while st_req_valid = 1.
  - Clears on a store grant, or in any cycle where st_req_valid = 0.
- Flush (loads only):
  - REQ holding a load, flush with dc_ready = 0: drop to IDLE, dc_req deasserts next cycle.
  - REQ holding a load, flush with dc_ready = 1: go to WAIT with kill = 1.
  - WAIT holding a load: set kill = 1; the response is swallowed and the FSM still returns to IDLE on dc_rvalid.
  - kill clears on return to IDLE.
  - Flush in IDLE: load not granted; a pending store may still be granted.
  - Flush has no effect on a store in any state.
- dc_rvalid outside WAIT is ignored. No outputs change.
- Reset mid-transaction: immediate return to IDLE, all outputs 0. The cache is reset concurrently by the system.
- Width rules:
  - dc_addr = {(30-ADDR_W)'b0, addr}.
  - For loads: dc_be = 0 and dc_wdata = 0.
  - For stores: dc_be = latched be; dc_be = 0000 is still issued as a write.

Test Plan:
- Single load: addr 0x0040, pw 7, tag 3; dc_ready on the first REQ cycle; dc_rvalid 2 cycles later with rdata 0xDEADBEEF → dc_req one cycle, dc_addr 0x0000040, dc_we 0; ld_resp_valid one cycle with pw 7, tag 3, data 0xDEADBEEF; busy drops the next cycle.
- Store backpressure: store addr 0x0010, be 0011, data 0x12345678; dc_ready held low 3 cycles → dc_req and all fields stable for 4 cycles; st_ack on dc_rvalid; ld_req_ready stays 0 throughout.
- Starvation, STARVE_LIMIT = 4: loads and a store valid continuously, cache answers in 1 cycle → grant sequence L,L,L,L,S,L…; with st_urgent = 1 from the start the store is granted first.
- Flush in WAIT for a load (pw 9) → no ld_resp_valid on dc_rvalid; FSM reaches IDLE; the next load completes normally.
- Flush in REQ for a load: with dc_ready = 0 → dc_req deasserts next cycle, no cache access. With dc_ready = 1 in the same cycle → WAIT, the response is suppressed.
- Flush during a store WAIT → st_ack still asserted; async reset asserted in REQ → all outputs 0 immediately, IDLE after release.
